bsg_nasti_mem_model: RTL and testbench

- Single-channel NASTI slave memory model that consumes one rocket's AW/W/AR channels and produces B/R responses. It sits directly downstream of the test system's nasti_* ports, one instance per rocket in the bench.
- Serves one transaction at a time from an internal word array.
- Provides deterministic, cycle-exact memory behaviour for system simulation.

---
 rtl/bsg_nasti_mem_model.sv | 175 +++++++++++++++++
 tb/tb_bsg_nasti_mem_model.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_nasti_mem_model.sv
//==============================================================================
// bsg_nasti_mem_model: one-transaction-at-a-time NASTI slave word memory. Rev 1.0
//==============================================================================
`default_nettype none

package bsg_nasti_pkg;
   typedef struct packed {
      logic [4:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } bsg_nasti_a_pkt;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } bsg_nasti_w_pkt;

   typedef struct packed {
      logic [4:0] id;
      logic [1:0] resp;
   } bsg_nasti_b_pkt;

   typedef struct packed {
      logic [4:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } bsg_nasti_r_pkt;
endpackage

module bsg_nasti_mem_model
   import bsg_nasti_pkg::*;
#(
   parameter int els_p        = 4096,
   parameter int data_width_p = 64
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           nasti_aw_valid_i,
   input  bsg_nasti_a_pkt nasti_aw_data_i,
   output logic           nasti_aw_ready_o,
   input  logic           nasti_w_valid_i,
   input  bsg_nasti_w_pkt nasti_w_data_i,
   output logic           nasti_w_ready_o,
   output logic           nasti_b_valid_o,
   output bsg_nasti_b_pkt nasti_b_data_o,
   input  logic           nasti_b_ready_i,
   input  logic           nasti_ar_valid_i,
   input  bsg_nasti_a_pkt nasti_ar_data_i,
   output logic           nasti_ar_ready_o,
   output logic           nasti_r_valid_o,
   output bsg_nasti_r_pkt nasti_r_data_o,
   input  logic           nasti_r_ready_i
);
   localparam int lg_els_lp = $clog2(els_p);

   typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

   state_e                  state;
   logic [4:0]              id_r;
   logic [lg_els_lp-1:0]    addr_r;
   logic [7:0]              len_r;
   logic [7:0]              cnt_r;
   logic                    err_r;
   logic                    last_read_r;
   logic [63:0]             r_data_r;
   logic [data_width_p-1:0] mem [els_p];

   logic                 grant_w, grant_r;
   logic                 aw_hs, ar_hs, w_hs, r_hs;
   logic                 at_len;
   logic [lg_els_lp-1:0] aw_word, ar_word, addr_nxt;
   logic                 unused_addr_bits;

   // Write wins a tie unless it won the previous grant.
   assign grant_w = nasti_aw_valid_i && (!nasti_ar_valid_i || last_read_r);
   assign grant_r = nasti_ar_valid_i && !grant_w;

   assign nasti_aw_ready_o = !reset_i && (state == IDLE) && grant_w;
   assign nasti_ar_ready_o = !reset_i && (state == IDLE) && grant_r;
   assign nasti_w_ready_o  = !reset_i && (state == WDATA);
   assign nasti_b_valid_o  = !reset_i && (state == WRESP);
   assign nasti_r_valid_o  = !reset_i && (state == RDATA);

   assign aw_hs = nasti_aw_valid_i && nasti_aw_ready_o;
   assign ar_hs = nasti_ar_valid_i && nasti_ar_ready_o;
   assign w_hs  = nasti_w_valid_i  && nasti_w_ready_o;
   assign r_hs  = nasti_r_ready_i  && nasti_r_valid_o;

   assign at_len   = (cnt_r == len_r);
   assign aw_word  = nasti_aw_data_i.addr[lg_els_lp+2:3];
   assign ar_word  = nasti_ar_data_i.addr[lg_els_lp+2:3];
   assign addr_nxt = addr_r + lg_els_lp'(1);

   assign unused_addr_bits = ^{nasti_aw_data_i.addr[31:lg_els_lp+3], nasti_aw_data_i.addr[2:0],
                               nasti_ar_data_i.addr[31:lg_els_lp+3], nasti_ar_data_i.addr[2:0]};

   assign nasti_b_data_o = '{id: id_r, resp: (err_r ? 2'b10 : 2'b00)};
   assign nasti_r_data_o = '{id: id_r, data: r_data_r, resp: 2'b00, last: at_len};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state       <= IDLE;
         id_r        <= '0;
         addr_r      <= '0;
         len_r       <= '0;
         cnt_r       <= '0;
         err_r       <= 1'b0;
         last_read_r <= 1'b1;
         r_data_r    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (aw_hs) begin
                  id_r        <= nasti_aw_data_i.id;
                  addr_r      <= aw_word;
                  len_r       <= nasti_aw_data_i.len;
                  cnt_r       <= '0;
                  err_r       <= 1'b0;
                  last_read_r <= 1'b0;
                  state       <= WDATA;
               end else if (ar_hs) begin
                  id_r        <= nasti_ar_data_i.id;
                  addr_r      <= ar_word;
                  len_r       <= nasti_ar_data_i.len;
                  cnt_r       <= '0;
                  last_read_r <= 1'b1;
                  r_data_r    <= mem[ar_word];
                  state       <= RDATA;
               end
            end
            WDATA: begin
               if (w_hs) begin
                  // Burst length is governed by len; a wrong last flag only taints resp.
                  err_r <= err_r | (nasti_w_data_i.last != at_len);
                  if (at_len) begin
                     state <= WRESP;
                  end else begin
                     cnt_r  <= cnt_r + 8'd1;
                     addr_r <= addr_nxt;
                  end
               end
            end
            WRESP: begin
               if (nasti_b_ready_i) state <= IDLE;
            end
            RDATA: begin
               if (r_hs) begin
                  if (at_len) begin
                     state <= IDLE;
                  end else begin
                     cnt_r    <= cnt_r + 8'd1;
                     addr_r   <= addr_nxt;
                     r_data_r <= mem[addr_nxt];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array contents survive reset; only strobed bytes of an accepted beat change.
   always_ff @(posedge clk_i) begin
      if (w_hs) begin
         for (int b = 0; b < 8; b++) begin
            if (nasti_w_data_i.strb[b]) mem[addr_r][8*b +: 8] <= nasti_w_data_i.data[8*b +: 8];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bsg_nasti_mem_model.sv
//==============================================================================
// tb_bsg_nasti_mem_model: directed self-checking bench for bsg_nasti_mem_model. Rev 1.0
//==============================================================================
`default_nettype none

module tb_bsg_nasti_mem_model;
   import bsg_nasti_pkg::*;

   logic           clk = 1'b0;
   logic           reset_i;
   logic           aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
   logic           ar_valid, ar_ready, r_valid, r_ready;
   bsg_nasti_a_pkt aw_data, ar_data;
   bsg_nasti_w_pkt w_data;
   bsg_nasti_b_pkt b_data;
   bsg_nasti_r_pkt r_data;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bsg_nasti_mem_model #(.els_p(16), .data_width_p(64)) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .nasti_aw_valid_i(aw_valid),
      .nasti_aw_data_i (aw_data),
      .nasti_aw_ready_o(aw_ready),
      .nasti_w_valid_i (w_valid),
      .nasti_w_data_i  (w_data),
      .nasti_w_ready_o (w_ready),
      .nasti_b_valid_o (b_valid),
      .nasti_b_data_o  (b_data),
      .nasti_b_ready_i (b_ready),
      .nasti_ar_valid_i(ar_valid),
      .nasti_ar_data_i (ar_data),
      .nasti_ar_ready_o(ar_ready),
      .nasti_r_valid_o (r_valid),
      .nasti_r_data_o  (r_data),
      .nasti_r_ready_i (r_ready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic aw_send(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len);
      aw_data  = '{id: id, addr: addr, len: len};
      aw_valid = 1'b1;
      #1 chk("aw_ready", {63'd0, aw_ready}, 64'd1);
      @(negedge clk);
      aw_valid = 1'b0;
   endtask

   task automatic ar_send(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len);
      ar_data  = '{id: id, addr: addr, len: len};
      ar_valid = 1'b1;
      #1 chk("ar_ready", {63'd0, ar_ready}, 64'd1);
      @(negedge clk);
      ar_valid = 1'b0;
   endtask

   task automatic w_beat(input logic [63:0] d, input logic [7:0] strb, input logic last);
      w_data  = '{data: d, strb: strb, last: last};
      w_valid = 1'b1;
      #1 chk("w_ready", {63'd0, w_ready}, 64'd1);
      @(negedge clk);
      w_valid = 1'b0;
   endtask

   task automatic b_expect(input logic [4:0] id, input logic [1:0] resp);
      #1;
      chk("b_valid", {63'd0, b_valid}, 64'd1);
      chk("b_id",    {59'd0, b_data.id}, {59'd0, id});
      chk("b_resp",  {62'd0, b_data.resp}, {62'd0, resp});
      b_ready = 1'b1;
      @(negedge clk);
      b_ready = 1'b0;
      #1 chk("b_valid_drop", {63'd0, b_valid}, 64'd0);
   endtask

   task automatic r_check(input logic [4:0] id, input logic [63:0] d, input logic last);
      chk("r_valid", {63'd0, r_valid}, 64'd1);
      chk("r_id",    {59'd0, r_data.id}, {59'd0, id});
      chk("r_data",  r_data.data, d);
      chk("r_last",  {63'd0, r_data.last}, {63'd0, last});
      chk("r_resp",  {62'd0, r_data.resp}, 64'd0);
   endtask

   task automatic r_beat(input logic [4:0] id, input logic [63:0] d, input logic last, input logic stall);
      if (stall) begin
         r_ready = 1'b0;
         #1 r_check(id, d, last);
         @(negedge clk);
      end
      r_ready = 1'b1;
      #1 r_check(id, d, last);
      @(negedge clk);
      r_ready = 1'b0;
   endtask

   initial begin
      reset_i  = 1'b1;
      aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
      ar_valid = 1'b0; r_ready = 1'b0;
      aw_data  = '0; ar_data = '0; w_data = '0;
      repeat (2) @(negedge clk);
      reset_i = 1'b0;
      #1;
      chk("rst_outs", {59'd0, aw_ready, ar_ready, w_ready, b_valid, r_valid}, 64'd0);
      @(negedge clk);

      // single-beat write, then read back
      aw_send(5'd3, 32'h40, 8'd0);
      w_beat(64'h1122334455667788, 8'hFF, 1'b1);
      b_expect(5'd3, 2'b00);
      ar_send(5'd5, 32'h40, 8'd0);
      r_beat(5'd5, 64'h1122334455667788, 1'b1, 1'b0);
      #1 chk("r_valid_drop", {63'd0, r_valid}, 64'd0);
      @(negedge clk);

      // four-beat burst, read back with back-pressure
      aw_send(5'd1, 32'h100, 8'd3);
      w_beat(64'hA0, 8'hFF, 1'b0);
      w_beat(64'hA1, 8'hFF, 1'b0);
      w_beat(64'hA2, 8'hFF, 1'b0);
      w_beat(64'hA3, 8'hFF, 1'b1);
      b_expect(5'd1, 2'b00);
      ar_send(5'd2, 32'h100, 8'd3);
      r_beat(5'd2, 64'hA0, 1'b0, 1'b0);
      r_beat(5'd2, 64'hA1, 1'b0, 1'b1);
      r_beat(5'd2, 64'hA2, 1'b0, 1'b0);
      r_beat(5'd2, 64'hA3, 1'b1, 1'b1);
      #1 chk("burst_end", {63'd0, r_valid}, 64'd0);
      @(negedge clk);

      // byte strobes
      aw_send(5'd4, 32'h28, 8'd0);
      w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
      b_expect(5'd4, 2'b00);
      aw_send(5'd4, 32'h28, 8'd0);
      w_beat(64'h0, 8'h0F, 1'b1);
      b_expect(5'd4, 2'b00);
      ar_send(5'd6, 32'h28, 8'd0);
      r_beat(5'd6, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0);

      // arbitration ties starting from reset
      reset_i = 1'b1;
      @(negedge clk);
      reset_i  = 1'b0;
      aw_data  = '{id: 5'd11, addr: 32'h10, len: 8'd0};
      ar_data  = '{id: 5'd12, addr: 32'h10, len: 8'd0};
      aw_valid = 1'b1;
      ar_valid = 1'b1;
      #1;
      chk("tie1_aw", {63'd0, aw_ready}, 64'd1);
      chk("tie1_ar", {63'd0, ar_ready}, 64'd0);
      @(negedge clk);
      aw_valid = 1'b0;
      #1 chk("ar_blocked", {63'd0, ar_ready}, 64'd0);
      w_beat(64'h55, 8'hFF, 1'b1);
      b_expect(5'd11, 2'b00);
      aw_data  = '{id: 5'd13, addr: 32'h18, len: 8'd0};
      aw_valid = 1'b1;
      #1;
      chk("tie2_ar", {63'd0, ar_ready}, 64'd1);
      chk("tie2_aw", {63'd0, aw_ready}, 64'd0);
      @(negedge clk);
      ar_valid = 1'b0;
      r_beat(5'd12, 64'h55, 1'b1, 1'b0);
      #1 chk("aw_after_rd", {63'd0, aw_ready}, 64'd1);
      @(negedge clk);
      aw_valid = 1'b0;
      w_beat(64'h66, 8'hFF, 1'b1);
      b_expect(5'd13, 2'b00);

      // wrap around the array end with an early last flag
      aw_send(5'd7, 32'h78, 8'd1);
      w_beat(64'hBB0, 8'hFF, 1'b1);
      w_beat(64'hBB1, 8'hFF, 1'b1);
      b_expect(5'd7, 2'b10);
      ar_send(5'd8, 32'h78, 8'd1);
      r_beat(5'd8, 64'hBB0, 1'b0, 1'b0);
      r_beat(5'd8, 64'hBB1, 1'b1, 1'b0);

      // reset in the middle of a write burst
      aw_send(5'd9, 32'h40, 8'd3);
      w_beat(64'hC0, 8'hFF, 1'b0);
      w_beat(64'hC1, 8'hFF, 1'b0);
      w_data  = '{data: 64'hC2, strb: 8'hFF, last: 1'b0};
      w_valid = 1'b1;
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      w_valid = 1'b0;
      #1 chk("midrst_outs", {59'd0, aw_ready, ar_ready, w_ready, b_valid, r_valid}, 64'd0);
      @(negedge clk);
      #1 chk("midrst_no_b", {63'd0, b_valid}, 64'd0);
      aw_send(5'd10, 32'h60, 8'd0);
      w_beat(64'h77, 8'hFF, 1'b1);
      b_expect(5'd10, 2'b00);
      ar_send(5'd14, 32'h60, 8'd0);
      r_beat(5'd14, 64'h77, 1'b1, 1'b0);
      ar_send(5'd15, 32'h40, 8'd0);
      r_beat(5'd15, 64'hC0, 1'b1, 1'b0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
